shift_tx_controller: RTL

Sequencing controller for a right-shift serial output path. It accepts a parallel word through a valid/ready handshake, loads it into an internal right-shift register, and shifts it out LSB-first on a single serial line. Each bit is held for a programmable number of clock cycles. It reports completion with a one-cycle done pulse and sits between a parallel producer (CPU/FSM) and a serial sink (LED chain, shift-out pin, downstream shift register).

---
 rtl/shift_tx_controller.sv | 117 +++++++++++
 1 files changed

// File: rtl/shift_tx_controller.sv
// rtl/shift_tx_controller.sv - LSB-first serial transmit controller with valid/ready load and per-bit hold divider
//
// Ports:
//   clk         clock, all state updates on its rising edge
//   rst         asynchronous active-high reset
//   din         parallel word, sampled only on the load handshake
//   load_valid  producer has a word on din
//   load_ready  controller is idle and will take a word this cycle
//   abort       synchronous cancel of the current frame (highest priority)
//   SO          serial output, LSB first, low outside SHIFT
//   shift_en    strobe on each cycle the internal register shifts
//   busy        high while in SHIFT or DONE
//   done        one-cycle pulse after the last bit has been held
module shift_tx_controller #(
    parameter int WIDTH = 8,
    parameter int DIV   = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic             abort,
    output logic             SO,
    output logic             shift_en,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [CW-1:0] BIT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0] BIT_ONE  = CW'(1);
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [DW-1:0] DIV_ONE  = DW'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    bit_cnt;
    logic [DW-1:0]    div_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            sr         <= '0;
            bit_cnt    <= '0;
            div_cnt    <= '0;
            load_ready <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else if (abort) begin
            // Abort wins over everything, including a handshake in the same
            // cycle: the offered word is consumed and dropped.
            state      <= IDLE;
            sr         <= '0;
            bit_cnt    <= '0;
            div_cnt    <= '0;
            load_ready <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_valid) begin
                        state      <= SHIFT;
                        sr         <= din;
                        bit_cnt    <= BIT_FULL;
                        div_cnt    <= DIV_LAST;
                        load_ready <= 1'b0;
                        busy       <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (div_cnt == '0) begin
                        sr      <= {1'b0, sr[WIDTH-1:1]};
                        bit_cnt <= bit_cnt - BIT_ONE;
                        div_cnt <= DIV_LAST;
                        if (bit_cnt == BIT_ONE) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end
                    end else begin
                        div_cnt <= div_cnt - DIV_ONE;
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    done       <= 1'b0;
                    busy       <= 1'b0;
                    load_ready <= 1'b1;
                end
                default: begin
                    state      <= IDLE;
                    sr         <= '0;
                    bit_cnt    <= '0;
                    div_cnt    <= '0;
                    load_ready <= 1'b1;
                    busy       <= 1'b0;
                    done       <= 1'b0;
                end
            endcase
        end
    end

    // Both are pure decodes of flops, so an async reset clears them at once.
    // The last cycle of each bit's hold window is the cycle that shifts.
    assign shift_en = (state == SHIFT) && (div_cnt == '0);
    assign SO       = (state == SHIFT) && sr[0];

endmodule
